mrnaiso_sequencer: RTL

MRNAISO_SEQUENCER -- requirements
Module: mrnaiso_sequencer

---
 rtl/mrnaiso_pkg.sv | 67 ++++++
 rtl/mrnaiso_tick_gen.sv | 30 +++
 rtl/mrnaiso_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/mrnaiso_pkg.sv
// Shared definitions for the mRNA isolation sequencer: state encoding,
// valve bit map, peristaltic pump phase table and the per-state valve pattern.
package mrnaiso_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_CELLS = 4'd1,
    ST_LOAD_BEADS = 4'd2,
    ST_LYSIS      = 4'd3,
    ST_MIX        = 4'd4,
    ST_SEPARATE   = 4'd5,
    ST_WASTE      = 4'd6,
    ST_COLLECT    = 4'd7
  } state_t;

  localparam int NUM_VALVES  = 13;
  localparam int V_COLLECT   = 0;
  localparam int V_LYSIS_IN  = 1;
  localparam int V_LYSIS_OUT = 2;
  localparam int V_PUSH      = 3;
  localparam int V_PUMP1     = 4;
  localparam int V_PUMP2     = 5;
  localparam int V_PUMP3     = 6;
  localparam int V_SEP       = 7;
  localparam int V_SIEVE     = 8;
  localparam int V_WASTE     = 9;
  localparam int V_BEADS     = 10;
  localparam int V_CELLS_IN  = 11;
  localparam int V_CELLS_OUT = 12;

  // Pump valves {pump3, pump2, pump1}; 1 = closed. Six-phase peristaltic wave.
  localparam int NUM_PHASES = 6;
  localparam logic [2:0] PUMP_PHASE [NUM_PHASES] = '{
    3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
  };

  // Valve drive for a given state; everything not opened stays pressurised.
  function automatic logic [NUM_VALVES-1:0] valve_pattern(input state_t s,
                                                          input logic [2:0] phase);
    logic [NUM_VALVES-1:0] v;
    v = '1;
    case (s)
      ST_LOAD_CELLS: begin
        v[V_CELLS_IN]  = 1'b0;
        v[V_CELLS_OUT] = 1'b0;
      end
      ST_LOAD_BEADS: v[V_BEADS] = 1'b0;
      ST_LYSIS: begin
        v[V_LYSIS_IN]  = 1'b0;
        v[V_LYSIS_OUT] = 1'b0;
      end
      ST_MIX:      v[V_PUMP3:V_PUMP1] = PUMP_PHASE[phase];
      ST_SEPARATE: v[V_SEP] = 1'b0;
      ST_WASTE: begin
        v[V_WASTE] = 1'b0;
        v[V_PUSH]  = 1'b0;
      end
      ST_COLLECT: begin
        v[V_COLLECT] = 1'b0;
        v[V_PUSH]    = 1'b0;
      end
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mrnaiso_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clocks; synchronous clear
// restarts the count so every state begins on a fresh tick boundary.
module mrnaiso_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == CNT_LAST);

  // Count clocks, wrapping on the tick cycle or restarting on clear.
  // NOTE: an asynchronous reset belongs in the sensitivity list; the reset branch must come first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mrnaiso_sequencer.sv
// Fixed-order mRNA isolation sequencer: walks LOAD_CELLS..COLLECT on prescaled
// ticks, driving the control valves, with abort and a completion pulse.
module mrnaiso_sequencer
  import mrnaiso_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int STEP_TICKS = 16,
  parameter int MIX_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [12:0] valve_ctrl,
  output logic [3:0]  step,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] STEP_LAST = 16'(STEP_TICKS - 1);
  localparam logic [15:0] MIX_LAST  = 16'(NUM_PHASES * MIX_CYCLES - 1);
  localparam logic [2:0]  PH_LAST   = 3'(NUM_PHASES - 1);

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  phase_q, phase_d;
  logic [12:0] valve_d;
  logic        done_d;
  logic        tick, expire, clear;

  mrnaiso_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // The tick counter is only compared for equality; leaving the state stops it.
  assign expire = tick && (tick_cnt_q == ((state_q == ST_MIX) ? MIX_LAST : STEP_LAST));
  // Any state change (and all of IDLE) restarts prescaler, tick count and phase.
  assign clear  = (state_d != state_q) || (state_q == ST_IDLE);

  // State, tick counter and pump phase registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Next state: start from IDLE, abort beats expiry, strict encoding order.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      ST_IDLE: if (start && !abort) state_d = ST_LOAD_CELLS;
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = (state_q == ST_COLLECT) ? ST_IDLE : state_t'(state_q + 4'd1);
        end
      end
    endcase
    if (clear) begin
      tick_cnt_d = '0;
      phase_d    = '0;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
      if (state_q == ST_MIX) phase_d = (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
    end
  end

  // Registered outputs are computed from the next state so they move with it.
  always_comb begin
    valve_d = valve_pattern(state_d, phase_d);
    done_d  = (state_q == ST_COLLECT) && expire && !abort;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_ctrl <= 13'h1FFF;
      done       <= 1'b0;
    end else begin
      valve_ctrl <= valve_d;
      done       <= done_d;
    end
  end

  assign step = state_q;
  assign busy = (state_q != ST_IDLE);

endmodule
